multi_lat_valid: RTL
====================

Name: multi_lat_valid

Overview:
- Matching pipe for the shared arithmetic unit when ops of different latency (e.g. mul, div, sqrt) share one result port.
- Carries valid plus a WIDTH-bit tag through a per-op latency selected by a MODE input, so the tag emerges exactly when that op's result does.
- Adds what a fixed-latency valid pipe lacks:
  - per-op latency;
  - result-slot collision back-pressure;
  - pipeline stall;
  - flush;
  - in-flight count.

Parameters:
- WIDTH, 1, tag width carried alongside valid.
- LAT0, 4, latency in cycles for mode 0 (≥1).
- LAT1, 8, latency for mode 1 (≥1).
- LAT2, 16, latency for mode 2 (≥1).
- LAT3, 1, latency for mode 3 (≥1).
- MAXLAT, derived localparam = max(LAT0..LAT3); not overridable.

Ports:
- clk  in  1  clock.
- reset_l  in  1  asynchronous active-low reset.
- en  in  1  pipeline advance enable; 0 = stall, matching the arithmetic unit's stall.
- flush  in  1  synchronous clear of all in-flight entries.
- i_valid  in  1  op issue request.
- i_mode  in  2  selects LAT0..LAT3 for this op.
- i_tag  in  WIDTH  tag to carry.
- i_ready  out  1  issue accepted this cycle when i_valid & i_ready.
- o_valid  out  1  result valid.
- o_tag  out  WIDTH  tag of the emerging result.
- inflight  out  $clog2(MAXLAT+1)  number of occupied slots.

Behaviour:
- Storage: slot array s[0..MAXLAT-1], each slot holds {v, tag}.
  - o_valid = s[0].v; o_tag = s[0].tag (registered outputs, no combinational path from inputs).
  - s[MAXLAT] is treated as constant empty.
- Reset (reset_l low, async): all s[k].v = 0, tags = 0, so o_valid = 0, o_tag = 0, inflight = 0. i_ready = 0 while reset_l is low.
- Let L = LAT[i_mode].
- Combinational i_ready = en & ~flush & ~s[L].v.
  - s[L] is the slot that shifts into s[L-1] this cycle; if it is occupied, the result port would collide.
  - When L = MAXLAT, i_ready = en & ~flush.
- Clock edge with flush = 1: all s[k].v <= 0. Tags don't care, but are held. inflight <= 0. Flush overrides en and i_valid.
- Clock edge with en = 1, flush = 0:
  - s[k] <= s[k+1] for k = 0..MAXLAT-2; s[MAXLAT-1] <= empty.
  - If i_valid & i_ready, s[L-1] <= {1, i_tag} after the shift.
- Clock edge with en = 0, flush = 0: all slots hold, and o_valid/o_tag hold. A stalled o_valid = 1 is presented for more than one cycle; the consumer qualifies with en.
- Latency: op accepted at edge t (i_valid & i_ready sampled) gives o_valid = 1, o_tag = i_tag during cycle t+L counted in enabled cycles. Stalled cycles extend it 1:1.
- Ordering: outputs need not match issue order (a short op may overtake a long one). Consumers rely on the tag.
- Collision rule: at most one result per cycle, guaranteed by i_ready. The issuer holds i_valid, i_mode and i_tag until accepted.
- inflight:
  - +1 on accept; −1 when en = 1 and s[0].v = 1 (entry leaves).
  - Both in one cycle gives no change.
  - Never exceeds MAXLAT; flush sets 0.
- LAT = 1: the op writes s[0] directly. This is legal and collides only when s[1].v.
- Width rules: tags are copied unmodified; no arithmetic on tags.

Decomposition:
- Shared package: a typedef for the slot struct {logic v; logic [WIDTH-1:0] tag} is not possible package-wide because it is parametric, so define it locally.
- Shared package holds:
  - the mode encoding constants MODE_MUL = 0, MODE_DIV = 1, MODE_SQRT = 2, MODE_PASS = 3;
  - a function max4() used for MAXLAT.
- Sub-module: none required. The slot shift register is one always_ff. An optional sub-module lat_slot (one slot with load/shift/flush) is allowed but not required.

Test Plan:
- Single op: LAT1 = 8, mode 1, tag 0x1 issued at cycle 10, en = 1 → o_valid = 1, o_tag = 1 at cycle 18 only; inflight 1 over cycles 11-18, 0 at cycle 19.
- Overtake: mode 2 tag A at cycle 0 (L = 16), mode 0 tag B at cycle 1 (L = 4) → B out at cycle 5, A out at cycle 16; inflight peaks at 2.
- Collision: mode 1 (L = 8) at cycle 0, then mode 0 (L = 4) request at cycle 4 → i_ready = 0 at cycle 4 (s[4] occupied); the request is accepted at cycle 5 and emerges at cycle 9; the mode 1 op still emerges at cycle 8.
- Stall: mode 0 at cycle 0, en = 0 for cycles 2-4 → o_valid at cycle 7 (4 + 3); i_ready = 0 during the stall; o_valid/o_tag held if the stall coincides with output.
- Flush mid-flight: three ops in flight, flush = 1 at cycle 6 → o_valid = 0 from cycle 7 on, inflight = 0, no late outputs; an issue attempted during flush is refused (i_ready = 0).
- Async reset mid-operation: reset_l low between edges with ops in flight → o_valid, inflight go 0 immediately; after release, a new op has normal latency.

Source files
------------

// File: rtl/multi_lat_valid_pkg.sv
// Purpose : shared mode encoding and helpers for the multi-latency valid/tag pipe.
// Latency : n/a (constants and a compile-time helper only).
// Backpressure: n/a.
package multi_lat_valid_pkg;

    // Op modes presented on i_mode; each selects one of LAT0..LAT3.
    localparam logic [1:0] MODE_MUL  = 2'd0;
    localparam logic [1:0] MODE_DIV  = 2'd1;
    localparam logic [1:0] MODE_SQRT = 2'd2;
    localparam logic [1:0] MODE_PASS = 2'd3;

    // Largest of four latencies; sizes the slot array.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/multi_lat_valid.sv
// Purpose : carries valid + tag through a per-mode latency so the tag emerges with the op's result.
// Latency : LAT[i_mode] enabled cycles from accept to o_valid; stalled cycles (en=0) add 1:1.
// Backpressure: i_ready drops on stall, flush, or when the op's result slot would collide.
// Ports   : clk/reset_l (async active-low); en advance enable; flush clears in-flight ops;
//           i_valid/i_mode/i_tag/i_ready issue handshake; o_valid/o_tag result; inflight count.
module multi_lat_valid
    import multi_lat_valid_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int LAT0  = 4,
    parameter int LAT1  = 8,
    parameter int LAT2  = 16,
    parameter int LAT3  = 1,
    localparam int MAXLAT = max4(LAT0, LAT1, LAT2, LAT3),
    localparam int CW     = $clog2(MAXLAT + 1)
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             en,
    input  logic             flush,
    input  logic             i_valid,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_tag,
    output logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_tag,
    output logic [CW-1:0]    inflight
);

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] tag;
    } slot_t;

    // slots[0] drives the result port; an op of latency L lands in slots[L-1].
    slot_t           slots    [MAXLAT];
    slot_t           slots_nx [MAXLAT];
    logic [MAXLAT:0] occ;      // occupancy with a constant-empty slot at index MAXLAT
    logic [CW-1:0]   lat_sel;
    logic [CW-1:0]   wr_idx;
    logic            accept;

    always_comb begin
        case (i_mode)
            MODE_MUL:  lat_sel = CW'(LAT0);
            MODE_DIV:  lat_sel = CW'(LAT1);
            MODE_SQRT: lat_sel = CW'(LAT2);
            default:   lat_sel = CW'(LAT3);
        endcase
    end

    always_comb begin
        occ = '0;
        for (int k = 0; k < MAXLAT; k++) begin
            occ[k] = slots[k].v;
        end
    end

    // The entry in slots[L] moves into slots[L-1] this edge, so a new op of
    // latency L would land on top of it: refuse the issue until it has passed.
    assign i_ready = reset_l & en & ~flush & ~occ[lat_sel];
    assign accept  = i_valid & i_ready;
    assign wr_idx  = lat_sel - CW'(1);

    // Next slot contents for an enabled edge: shift toward slot 0, then insert.
    always_comb begin
        for (int k = 0; k < MAXLAT - 1; k++) begin
            slots_nx[k] = slots[k + 1];
        end
        slots_nx[MAXLAT-1] = '0;
        for (int k = 0; k < MAXLAT; k++) begin
            if (accept && (wr_idx == CW'(k))) begin
                slots_nx[k] = {1'b1, i_tag};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            for (int k = 0; k < MAXLAT; k++) begin
                slots[k] <= '0;
            end
            inflight <= '0;
        end else if (flush) begin
            // Only the valid bits are cleared; stale tags are harmless.
            for (int k = 0; k < MAXLAT; k++) begin
                slots[k].v <= 1'b0;
            end
            inflight <= '0;
        end else if (en) begin
            for (int k = 0; k < MAXLAT; k++) begin
                slots[k] <= slots_nx[k];
            end
            // accept and an exiting result in the same cycle cancel out.
            inflight <= inflight + CW'(accept) - CW'(slots[0].v);
        end
    end

    assign o_valid = slots[0].v;
    assign o_tag   = slots[0].tag;

endmodule
